// File: rtl/memory_stage.sv
// MEM stage plus MEM/WB register: data memory, 16-bit stack, two-cycle CALL/RET.
// Optional stack over/underflow protection enabled by defining STACK_GUARD_EN.
module memory_stage #(
   parameter int                    ADDR_WIDTH = 11,
   parameter logic [ADDR_WIDTH-1:0] SP_RESET   = {ADDR_WIDTH{1'b1}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  call,
   input  logic                  ret,
   input  logic [15:0]           alu_value,
   input  logic [15:0]           store_data,
   input  logic [15:0]           immediate_in,
   input  logic [15:0]           input_port_in,
   input  logic [31:0]           pc_in,
   input  logic [1:0]            wb_sel_in,
   input  logic                  wb_en_in,
   input  logic [2:0]            rdst_in,
   output logic                  stall,
   output logic [15:0]           mem_data_out,
   output logic [15:0]           alu_value_out,
   output logic [15:0]           immediate_out,
   output logic [15:0]           input_port_out,
   output logic [1:0]            wb_sel_out,
   output logic                  wb_en_out,
   output logic [2:0]            rdst_out,
   output logic [31:0]           ret_pc,
   output logic                  ret_valid,
   output logic [ADDR_WIDTH-1:0] sp,
   output logic                  stack_fault
);

   // state   | meaning
   // S_IDLE  | single-cycle ops; call/ret start here and stall upstream
   // S_CALL2 | second call cycle: push low PC word
   // S_RET2  | second ret cycle: pop high PC word, present ret_pc
   typedef enum logic [1:0] {S_IDLE, S_CALL2, S_RET2} state_t;

   localparam int                    DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] SP_ONE = 1;

   logic [15:0] mem [DEPTH];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr, sp_inc, sp_dec, sp_d;
   logic [15:0]           rd_addr, rd_sp1, low_word_q;
   logic                  ovf, unf, fault_now, bubble;
   logic                  mem_we, md_load, low_load, rpc_load;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [15:0]           mem_wdata, md_d;

   assign addr    = alu_value[ADDR_WIDTH-1:0];
   assign sp_inc  = sp + SP_ONE;
   assign sp_dec  = sp - SP_ONE;
   assign rd_addr = mem[addr];
   assign rd_sp1  = mem[sp_inc];

`ifdef STACK_GUARD_EN
   assign ovf = (sp == '0);
   assign unf = (sp == SP_RESET);
   // A suppressed call/ret does not stall, so upstream is never frozen on a faulting op.
   assign stall = (state_q == S_IDLE) && (call || ret) && !fault_now;
`else
   assign ovf   = 1'b0;
   assign unf   = 1'b0;
   assign stall = (state_q == S_IDLE) && (call || ret);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (call) begin
               if (!ovf) state_d = S_CALL2;
            end else if (ret) begin
               if (!unf) state_d = S_RET2;
            end
         end
         S_CALL2: state_d = S_IDLE;
         S_RET2:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = sp;
      mem_wdata = store_data;
      sp_d      = sp;
      md_load   = 1'b0;
      md_d      = rd_sp1;
      low_load  = 1'b0;
      rpc_load  = 1'b0;
      bubble    = 1'b0;
      fault_now = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (call) begin
               bubble = 1'b1;
               if (ovf) fault_now = 1'b1;
               else begin
                  mem_we    = 1'b1;
                  mem_wdata = pc_in[31:16];
                  sp_d      = sp_dec;
               end
            end else if (ret) begin
               bubble = 1'b1;
               if (unf) fault_now = 1'b1;
               else begin
                  low_load = 1'b1;
                  md_load  = 1'b1;
                  sp_d     = sp_inc;
               end
            end else if (push) begin
               if (ovf) begin
                  fault_now = 1'b1;
                  bubble    = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  sp_d   = sp_dec;
               end
            end else if (pop) begin
               if (unf) begin
                  fault_now = 1'b1;
                  bubble    = 1'b1;
               end else begin
                  md_load = 1'b1;
                  sp_d    = sp_inc;
               end
            end else if (mem_write) begin
               mem_we    = 1'b1;
               mem_waddr = addr;
            end else if (mem_read) begin
               md_load = 1'b1;
               md_d    = rd_addr;
            end
         end
         S_CALL2: begin
            if (ovf) begin
               fault_now = 1'b1;
               bubble    = 1'b1;
            end else begin
               mem_we    = 1'b1;
               mem_wdata = pc_in[15:0];
               sp_d      = sp_dec;
            end
         end
         S_RET2: begin
            if (unf) begin
               fault_now = 1'b1;
               bubble    = 1'b1;
            end else begin
               md_load  = 1'b1;
               rpc_load = 1'b1;
               sp_d     = sp_inc;
            end
         end
         default: ;
      endcase
   end

   // Storage is not reset; writes are blocked while reset is held so an aborted frame stays partial.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp             <= SP_RESET;
         mem_data_out   <= '0;
         alu_value_out  <= '0;
         immediate_out  <= '0;
         input_port_out <= '0;
         wb_sel_out     <= '0;
         wb_en_out      <= 1'b0;
         rdst_out       <= '0;
         ret_pc         <= '0;
         ret_valid      <= 1'b0;
         low_word_q     <= '0;
      end else begin
         sp             <= sp_d;
         alu_value_out  <= alu_value;
         immediate_out  <= immediate_in;
         input_port_out <= input_port_in;
         wb_sel_out     <= wb_sel_in;
         wb_en_out      <= wb_en_in && !bubble;
         rdst_out       <= rdst_in;
         ret_valid      <= rpc_load;
         if (md_load)  mem_data_out <= md_d;
         if (low_load) low_word_q   <= rd_sp1;
         if (rpc_load) ret_pc       <= {rd_sp1, low_word_q};
      end
   end

`ifdef STACK_GUARD_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            stack_fault <= 1'b0;
      else if (fault_now) stack_fault <= 1'b1;
   end
`else
   assign stack_fault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: randomized ops against a word-level stack/memory model.
// Expectations follow STACK_GUARD_EN when the bench is built with it defined.
module tb_memory_stage;

`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   localparam logic [10:0] SPR = 11'h7FF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_read = 0, mem_write = 0, push = 0, pop = 0, call = 0, ret = 0;
   logic [15:0] alu_value = 0, store_data = 0, immediate_in = 0, input_port_in = 0;
   logic [31:0] pc_in = 0;
   logic [1:0]  wb_sel_in = 0;
   logic        wb_en_in = 0;
   logic [2:0]  rdst_in = 0;
   logic        stall;
   logic [15:0] mem_data_out, alu_value_out, immediate_out, input_port_out;
   logic [1:0]  wb_sel_out;
   logic        wb_en_out;
   logic [2:0]  rdst_out;
   logic [31:0] ret_pc;
   logic        ret_valid;
   logic [10:0] sp;
   logic        stack_fault;

   memory_stage dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
      .call(call), .ret(ret), .alu_value(alu_value), .store_data(store_data),
      .immediate_in(immediate_in), .input_port_in(input_port_in), .pc_in(pc_in),
      .wb_sel_in(wb_sel_in), .wb_en_in(wb_en_in), .rdst_in(rdst_in), .stall(stall),
      .mem_data_out(mem_data_out), .alu_value_out(alu_value_out), .immediate_out(immediate_out),
      .input_port_out(input_port_out), .wb_sel_out(wb_sel_out), .wb_en_out(wb_en_out),
      .rdst_out(rdst_out), .ret_pc(ret_pc), .ret_valid(ret_valid), .sp(sp),
      .stack_fault(stack_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] md, alu, imm, inp;
      logic [1:0]  sel;
      logic        en;
      logic [2:0]  rdst;
      logic [31:0] rpc;
      logic        rv;
      logic [10:0] sp;
      logic        flt;
   } exp_t;

   typedef struct {
      int   due;
      logic s;
   } stall_t;

   exp_t   exp_q[$];
   stall_t stall_q[$];
   int     cyc = 0;
   int     n_chk = 0;
   int     n_fail = 0;

   // reference model: plain word array, stack pointer and two "second cycle pending" flags
   logic [15:0] m_mem [2048];
   logic [10:0] m_sp = SPR;
   logic [15:0] m_md = 0, m_low = 0;
   logic [31:0] m_rpc = 0;
   logic        m_flt = 0;
   bit          call_pend = 0, ret_pend = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         while (stall_q.size() > 0 && stall_q[0].due <= cyc) begin
            stall_t s;
            s = stall_q.pop_front();
            chk("stall", {31'b0, stall}, {31'b0, s.s});
         end
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mem_data_out", {16'b0, mem_data_out}, {16'b0, e.md});
            chk("alu_value_out", {16'b0, alu_value_out}, {16'b0, e.alu});
            chk("immediate_out", {16'b0, immediate_out}, {16'b0, e.imm});
            chk("input_port_out", {16'b0, input_port_out}, {16'b0, e.inp});
            chk("wb_sel_out", {30'b0, wb_sel_out}, {30'b0, e.sel});
            chk("wb_en_out", {31'b0, wb_en_out}, {31'b0, e.en});
            chk("rdst_out", {29'b0, rdst_out}, {29'b0, e.rdst});
            chk("ret_pc", ret_pc, e.rpc);
            chk("ret_valid", {31'b0, ret_valid}, {31'b0, e.rv});
            chk("sp", {21'b0, sp}, {21'b0, e.sp});
            chk("stack_fault", {31'b0, stack_fault}, {31'b0, e.flt});
         end
      end
   end

   task automatic model_step();
      exp_t   e;
      stall_t s;
      e.en  = wb_en_in;
      e.rv  = 1'b0;
      s.due = cyc;
      s.s   = 1'b0;
      if (call_pend) begin
         call_pend = 0;
         if (GUARD && m_sp == 11'h000) begin m_flt = 1; e.en = 0; end
         else begin m_mem[m_sp] = pc_in[15:0]; m_sp = m_sp - 11'd1; end
      end else if (ret_pend) begin
         ret_pend = 0;
         if (GUARD && m_sp == SPR) begin m_flt = 1; e.en = 0; end
         else begin
            m_sp  = m_sp + 11'd1;
            m_md  = m_mem[m_sp];
            m_rpc = {m_mem[m_sp], m_low};
            e.rv  = 1'b1;
         end
      end else if (call) begin
         e.en = 0;
         if (GUARD && m_sp == 11'h000) m_flt = 1;
         else begin
            m_mem[m_sp] = pc_in[31:16];
            m_sp = m_sp - 11'd1;
            call_pend = 1;
            s.s = 1'b1;
         end
      end else if (ret) begin
         e.en = 0;
         if (GUARD && m_sp == SPR) m_flt = 1;
         else begin
            m_sp  = m_sp + 11'd1;
            m_low = m_mem[m_sp];
            m_md  = m_low;
            ret_pend = 1;
            s.s = 1'b1;
         end
      end else if (push) begin
         if (GUARD && m_sp == 11'h000) begin m_flt = 1; e.en = 0; end
         else begin m_mem[m_sp] = store_data; m_sp = m_sp - 11'd1; end
      end else if (pop) begin
         if (GUARD && m_sp == SPR) begin m_flt = 1; e.en = 0; end
         else begin m_sp = m_sp + 11'd1; m_md = m_mem[m_sp]; end
      end else if (mem_write) begin
         m_mem[alu_value[10:0]] = store_data;
      end else if (mem_read) begin
         m_md = m_mem[alu_value[10:0]];
      end
      e.due  = cyc + 1;
      e.md   = m_md;
      e.alu  = alu_value;
      e.imm  = immediate_in;
      e.inp  = input_port_in;
      e.sel  = wb_sel_in;
      e.rdst = rdst_in;
      e.rpc  = m_rpc;
      e.sp   = m_sp;
      e.flt  = m_flt;
      exp_q.push_back(e);
      stall_q.push_back(s);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic ops(input logic c, r, pu, po, mw, mr);
      call = c; ret = r; push = pu; pop = po; mem_write = mw; mem_read = mr;
   endtask

   task automatic rand_fields();
      alu_value     = 16'($urandom);
      if ($urandom_range(0, 1) == 0) alu_value[10:0] = 11'($urandom_range(0, 31));
      store_data    = 16'($urandom);
      immediate_in  = 16'($urandom);
      input_port_in = 16'($urandom);
      pc_in         = $urandom;
      wb_sel_in     = 2'($urandom);
      wb_en_in      = 1'($urandom);
      rdst_in       = 3'($urandom);
   endtask

   // entered just after a rising edge; leaves just after the next one with reset released
   task automatic do_reset();
      ops(0, 0, 0, 0, 0, 0);
      #6;
      rst = 1'b1;
      #1;
      chk("rst_sp", {21'b0, sp}, {21'b0, SPR});
      chk("rst_mem_data", {16'b0, mem_data_out}, 32'h0);
      chk("rst_alu", {16'b0, alu_value_out}, 32'h0);
      chk("rst_imm", {16'b0, immediate_out}, 32'h0);
      chk("rst_inport", {16'b0, input_port_out}, 32'h0);
      chk("rst_wb_sel", {30'b0, wb_sel_out}, 32'h0);
      chk("rst_wb_en", {31'b0, wb_en_out}, 32'h0);
      chk("rst_rdst", {29'b0, rdst_out}, 32'h0);
      chk("rst_ret_pc", ret_pc, 32'h0);
      chk("rst_ret_valid", {31'b0, ret_valid}, 32'h0);
      chk("rst_fault", {31'b0, stack_fault}, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      exp_q.delete();
      stall_q.delete();
      m_sp = SPR; m_md = 0; m_rpc = 0; m_flt = 0; m_low = 0;
      call_pend = 0; ret_pend = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 2048; i++) begin
         rand_fields();
         ops(0, 0, 0, 0, 1, 0);
         alu_value[10:0] = 11'(i);
         tick();
      end

      rand_fields(); ops(0, 0, 0, 0, 1, 0); alu_value = 16'h0010; store_data = 16'hBEEF; tick();
      rand_fields(); ops(0, 0, 0, 0, 0, 1); alu_value = 16'h0010; wb_sel_in = 2'b10; tick();
      rand_fields(); ops(0, 0, 1, 0, 0, 0); store_data = 16'h1234; tick();
      rand_fields(); ops(0, 0, 1, 0, 0, 0); store_data = 16'h5678; tick();
      rand_fields(); ops(0, 0, 0, 1, 0, 0); tick();
      rand_fields(); ops(0, 0, 0, 1, 0, 0); tick();

      rand_fields(); ops(1, 0, 0, 0, 0, 0); pc_in = 32'h0001_ABCD; tick();
      rand_fields(); ops(0, 0, 0, 0, 0, 0); pc_in = 32'h0001_ABCD; tick();
      rand_fields(); ops(0, 0, 0, 0, 0, 1); alu_value = 16'h07FF; tick();
      rand_fields(); ops(0, 0, 0, 0, 0, 1); alu_value = 16'h07FE; tick();
      rand_fields(); ops(0, 1, 0, 0, 0, 0); tick();
      rand_fields(); ops(0, 0, 0, 0, 0, 0); tick();
      rand_fields(); tick();

      rand_fields(); ops(1, 0, 1, 0, 0, 0); pc_in = 32'h1234_5678; tick();
      rand_fields(); ops(0, 0, 1, 0, 0, 0); pc_in = 32'h1234_5678; tick();
      rand_fields(); ops(0, 1, 0, 1, 0, 0); tick();
      rand_fields(); ops(0, 0, 0, 0, 0, 0); tick();
      rand_fields(); tick();

      rand_fields(); ops(0, 0, 0, 1, 0, 0); tick();
      rand_fields(); ops(0, 0, 0, 0, 0, 0); tick();
      rand_fields(); ops(0, 0, 1, 0, 0, 0); tick();
      rand_fields(); ops(0, 0, 0, 0, 0, 0); tick();
      do_reset();

      rand_fields(); ops(1, 0, 0, 0, 0, 0); pc_in = 32'hCAFE_F00D; tick();
      do_reset();
      rand_fields(); ops(0, 0, 0, 0, 0, 1); alu_value = 16'h07FF; tick();
      rand_fields(); ops(0, 0, 1, 0, 0, 0); tick();
      rand_fields(); ops(0, 0, 1, 0, 0, 0); tick();
      rand_fields(); ops(0, 1, 0, 0, 0, 0); tick();
      do_reset();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            do_reset();
         end else begin
            rand_fields();
            ops($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            tick();
         end
      end

      ops(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      @(posedge clk);
      #1;
      chk("queue_drain", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage plus MEM/WB register, sitting directly upstream of the write-back stage. Performs data-memory loads/stores, 16-bit PUSH/POP through an internal stack pointer, and two-cycle CALL/RET that save/restore a 32-bit PC as two stack words. Registers the write-back selector, enable, destination and candidate data values so write-back can mux them one cycle later.

## Interface
- ADDR_WIDTH, 11, data-memory word-address width (2^ADDR_WIDTH 16-bit words)
- SP_RESET, 2^ADDR_WIDTH-1, stack-pointer value after reset (empty stack)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- mem_read, mem_write  in  1  load / store using alu_value as address
- push, pop  in  1  16-bit stack ops
- call, ret  in  1  32-bit PC stack ops (two cycles)
- alu_value  in  16  address for load/store; also forwarded
- store_data  in  16  data for store/push
- immediate_in, input_port_in  in  16  forwarded to write-back
- pc_in  in  32  return address saved by call
- wb_sel_in  in  2  write-back selector (00 imm, 01 alu, 10 mem, 11 in-port)
- wb_en_in  in  1  register-file write enable
- rdst_in  in  3  destination register
- stall  out  1  hold upstream stage this cycle
- mem_data_out, alu_value_out, immediate_out, input_port_out  out  16  MEM/WB data registers
- wb_sel_out  out  2;  wb_en_out  out  1;  rdst_out  out  3  MEM/WB control registers
- ret_pc  out  32  restored PC;  ret_valid  out  1  one-cycle strobe
- sp  out  ADDR_WIDTH  current stack pointer
- stack_fault  out  1  sticky stack error (see Configuration)

## Operation
- Memory: 2^ADDR_WIDTH x 16, synchronous write, combinational read, not reset. Address = alu_value[ADDR_WIDTH-1:0].
- Stack grows down; sp points to next free word. Arithmetic modulo 2^ADDR_WIDTH.
- Op priority if several asserted: call > ret > push > pop > mem_write > mem_read; lower ones ignored.
- push: mem[sp] <= store_data; sp <= sp-1.
- pop: mem_data_out <= mem[sp+1]; sp <= sp+1.
- mem_write: mem[addr] <= store_data. mem_read: mem_data_out <= mem[addr].
- FSM states IDLE, CALL2, RET2.
  - IDLE + call: mem[sp] <= pc_in[31:16]; sp-1; -> CALL2.
  - CALL2: mem[sp] <= pc_in[15:0]; sp-1; -> IDLE.
  - IDLE + ret: low word <= mem[sp+1]; sp+1; -> RET2.
  - RET2: ret_pc <= {mem[sp+1], low word}; sp+1; ret_valid <= 1; -> IDLE.
- stall = (state==IDLE) && (call||ret); combinational. In CALL2/RET2 op inputs are ignored except the held pc_in.
- MEM/WB register loads every cycle from *_in and alu_value; in the first cycle of call/ret wb_en_out <= 0 (bubble); second cycle passes wb fields through.
- mem_data_out holds its value when no read/pop/ret occurs.

## Timing
- Reset: state IDLE, sp=SP_RESET, all MEM/WB outputs 0, ret_pc 0, ret_valid 0, stack_fault 0.
- Load/pop latency: data on mem_data_out one cycle after the op cycle, aligned with wb_*_out.
- Store/push visible to a read in the next cycle; same-cycle read returns old data.
- ret_valid high exactly one cycle, the cycle after RET2.
- Reset asserted in CALL2/RET2: abort to IDLE; stack memory may hold a partial frame; sp returns to SP_RESET.

## Configuration
- STACK_GUARD_EN defined: push/call at sp==0 (overflow) or pop/ret at sp==SP_RESET (underflow) is suppressed (no write, sp unchanged, no state change, wb_en_out <= 0) and stack_fault sets, sticky until rst. A call faulting in CALL2 still returns to IDLE.
- Not defined: no checks, sp wraps freely, stack_fault tied 0.

## Test plan
- Reset: rst high mid-run -> sp=0x7FF, all outputs 0, state IDLE immediately (async).
- mem_write addr 0x0010 data 0xBEEF, then mem_read 0x0010 wb_sel 10 -> next cycle mem_data_out=0xBEEF, wb_sel_out=10.
- push 0x1234, push 0x5678, pop, pop -> sp 0x7FF->0x7FD->0x7FF; mem_data_out 0x5678 then 0x1234.
- call pc_in=0x0001_ABCD at sp=0x7FF -> stall 1 one cycle, mem[0x7FF]=0x0001, mem[0x7FE]=0xABCD, sp=0x7FD; ret -> stall 1 one cycle, ret_valid pulse with ret_pc=0x0001ABCD, sp=0x7FF.
- call+push same cycle -> only call executes.
- STACK_GUARD_EN: pop at sp=0x7FF -> sp unchanged, stack_fault=1, stays 1 until rst; without macro sp wraps to 0x000.
